packet_filter_cfg_master: RTL and testbench
===========================================

Name: packet_filter_cfg_master

Overview:
AXI-Lite initiator that drives the packet filter's s_axi_cfg register slave from a simple command/response stream, such as a rule loader or an on-chip management sequencer. It converts one command into one AXI-Lite write (AW+W→B) or read (AR→R) and returns status and read data on a response stream. Only one transaction is outstanding at a time. A watchdog turns a hung slave into an error response without violating AXI-Lite.

Parameters:
ADDR_W, 32, AXI-Lite address width
DATA_W, 32, AXI-Lite data width; WSTRB is not generated (slave side ties to all-ones)
TIMEOUT, 1024, cycles allowed from command accept to B/R handshake; 0 disables the watchdog

Ports:
axil_aclk  in  1  clock for all logic
axil_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready; high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  register byte address
cmd_wdata  in  DATA_W  write data; ignored for reads
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  response was produced by the watchdog
busy  out  1  state != IDLE
m_axil_awvalid/awaddr/awready  out/out/in  1/ADDR_W/1  write address channel
m_axil_wvalid/wdata/wready  out/out/in  1/DATA_W/1  write data channel
m_axil_bvalid/bresp/bready  in/in/out  1/2/1  write response channel
m_axil_arvalid/araddr/arready  out/out/in  1/ADDR_W/1  read address channel
m_axil_rvalid/rdata/rresp/rready  in/in/in/out  1/DATA_W/2/1  read data channel

Behaviour:
- Reset (async assert, synchronous release): state=IDLE. Every valid/ready output is 0, except cmd_ready=1. rsp_* data, addr and wdata outputs are 0. Counters are cleared.
- All outputs are registered. A reset mid-transaction abandons it; recovery of the slave is the system's job.
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, RSP, DRAIN.
- IDLE: on cmd_valid&&cmd_ready, capture addr/wdata. Next cycle, write: awvalid=wvalid=1, state WR. Read: arvalid=1, state RD.
- WR:
  - awvalid and wvalid drop independently on their own handshake; either order and same-cycle acceptance are legal.
  - When both have completed, go to WR_RESP with bready=1.
  - Valids never drop before their handshake.
- WR_RESP: on bvalid&&bready, capture bresp, rdata=0, bready=0, state RSP.
- RD: arvalid held until arready. Then state RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready, capture rdata/rresp, rready=0, state RSP.
- RSP: rsp_valid=1, payload stable until rsp_ready. Then go to IDLE, or to DRAIN if late_pending.
- Latency with an always-ready slave and rsp_ready=1: cmd accepted at cycle 0, AW/W or AR valid at cycle 1, B/R accepted at cycle 2, rsp_valid at cycle 3, cmd_ready at cycle 4.
- Watchdog counter:
  - Clears on command accept and increments in WR, WR_RESP, RD and RD_DATA.
  - At count==TIMEOUT-1 with no B/R handshake in that cycle: go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, and set late_pending.
  - A handshake in the same cycle as expiry wins; no timeout is reported.
- late_pending behaviour:
  - Outstanding aw/w/ar valids stay asserted until accepted.
  - bready/rready is asserted once the address phase is done, including during RSP.
  - The late B/R is consumed and discarded.
- DRAIN: wait for the remaining handshakes plus the discarded B/R, then go to IDLE. The watchdog does not run here. If the late response arrives during RSP, DRAIN lasts 1 cycle.
- cmd_ready is 0 outside IDLE; command back-to-back throughput is 1 per (latency+1) cycles.

Test Plan:
- Write 0x0000_0010 ← 0xDEAD_BEEF, slave always ready, bresp=00 → AW/W at cycle 1 with those values, rsp_valid at cycle 3, rsp_resp=00, rsp_rdata=0, rsp_timeout=0.
- AW accepted at cycle 1, W accepted at cycle 4, B at cycle 6 → wvalid held through cycle 4, awvalid dropped after cycle 1, bready only after cycle 4, rsp_valid at cycle 7.
- Read 0x0000_0020, slave returns 0x1234_5678 with rresp=00 after 3-cycle arready stall → araddr stable while stalled, rsp_rdata=0x1234_5678, rsp_resp=00; rsp_ready low 5 cycles → payload stable, cmd_ready=0.
- TIMEOUT=16, slave accepts AW/W but never sends B until cycle 40 → rsp_valid with rsp_resp=10, rsp_timeout=1 at cycle 17; after rsp_ready go to DRAIN; bready consumes B at 40; cmd_ready=1 at 41; next command completes normally.
- Read with rvalid arriving in exactly the expiry cycle (TIMEOUT=16) → normal response, rsp_timeout=0.
- axil_aresetn asserted while in WR_RESP → all m_axil valids/readys and rsp_valid go to 0 immediately (async), cmd_ready=1 after release, busy=0.

Source files
------------

// File: rtl/packet_filter_cfg_master.sv
// rtl/packet_filter_cfg_master.sv - AXI-Lite initiator turning cmd/rsp streams into single register transactions
module packet_filter_cfg_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              axil_aclk,
    input  logic              axil_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              m_axil_awvalid,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    input  logic              m_axil_awready,
    output logic              m_axil_wvalid,
    output logic [DATA_W-1:0] m_axil_wdata,
    input  logic              m_axil_wready,
    input  logic              m_axil_bvalid,
    input  logic [1:0]        m_axil_bresp,
    output logic              m_axil_bready,
    output logic              m_axil_arvalid,
    output logic [ADDR_W-1:0] m_axil_araddr,
    input  logic              m_axil_arready,
    input  logic              m_axil_rvalid,
    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    output logic              m_axil_rready
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_RSP, S_DRAIN} state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic              bready_q, bready_d, rready_q, rready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d, late_q, late_d, resp_done_q, resp_done_d;

    logic aw_left, w_left, ar_left, b_hs, r_hs, addr_done, expire, timeout_now;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        busy_d        = busy_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        late_d        = late_q;
        resp_done_d   = resp_done_q;
        timeout_now   = 1'b0;

        aw_left   = awvalid_q & ~m_axil_awready;
        w_left    = wvalid_q & ~m_axil_wready;
        ar_left   = arvalid_q & ~m_axil_arready;
        b_hs      = m_axil_bvalid & bready_q;
        r_hs      = m_axil_rvalid & rready_q;
        addr_done = wr_q ? !(aw_left || w_left) : !ar_left;
        expire    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

        // Address/data valids drop on their own handshake in every state, including after a timeout.
        if (!aw_left) awvalid_d = 1'b0;
        if (!w_left)  wvalid_d  = 1'b0;
        if (!ar_left) arvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wr_d        = cmd_write;
                    cnt_d       = '0;
                    late_d      = 1'b0;
                    resp_done_d = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (expire) begin
                    timeout_now = 1'b1;
                end else if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axil_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (expire) begin
                    timeout_now = 1'b1;
                end
            end
            S_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (expire) begin
                    timeout_now = 1'b1;
                end else if (!ar_left) begin
                    rready_d = 1'b1;
                    state_d  = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axil_rresp;
                    rsp_rdata_d   = m_axil_rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (expire) begin
                    timeout_now = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (late_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (!aw_left && !w_left && !ar_left && (resp_done_q || b_hs || r_hs)) begin
                    late_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_now) begin
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            late_d        = 1'b1;
            bready_d      = wr_q && addr_done;
            rready_d      = !wr_q && addr_done;
            state_d       = S_RSP;
        end

        // A watchdog-abandoned transaction still owes the slave its B/R handshake; swallow it.
        if (late_q && !resp_done_q) begin
            if (b_hs || r_hs) begin
                resp_done_d = 1'b1;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
            end else if (addr_done) begin
                bready_d = wr_q;
                rready_d = !wr_q;
            end
        end
    end

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            late_q        <= 1'b0;
            resp_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            late_q        <= late_d;
            resp_done_q   <= resp_done_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_packet_filter_cfg_master.sv
// tb/tb_packet_filter_cfg_master.sv - directed and randomized bench for packet_filter_cfg_master
module tb_packet_filter_cfg_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_mem   [16];
    logic [31:0] slave_mem [16];

    always #5 clk = ~clk;

    packet_filter_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .axil_aclk(clk), .axil_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
        .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wready(wready),
        .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
        .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
        .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sresp);
        int da, dw, db, ca, cw, cb;
        logic a_hs, w_hs, d_hs, a_done, w_done, d_done, done;
        logic [31:0] sa, sw, exp_rdata;
        da = $urandom_range(0, 3); dw = $urandom_range(0, 3); db = $urandom_range(0, 3);
        ca = 0; cw = 0; cb = 0; sa = '0; sw = '0;
        a_done = 0; w_done = !wr; d_hs = 0; d_done = 0; done = 0;
        exp_rdata = wr ? 32'h0 : ref_mem[addr[5:2]];
        if (wr) ref_mem[addr[5:2]] = data;
        check("rnd_cmd_ready", cmd_ready, 1);
        issue(wr, addr, data);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            awready = 0; wready = 0; arready = 0; a_hs = 0; w_hs = 0;
            if (!a_done) begin
                check(wr ? "rnd_awvalid" : "rnd_arvalid", wr ? awvalid : arvalid, 1);
                check(wr ? "rnd_awaddr" : "rnd_araddr", wr ? awaddr : araddr, addr);
                if (ca == da) begin
                    a_hs = 1; sa = wr ? awaddr : araddr;
                    if (wr) awready = 1; else arready = 1;
                end
                ca++;
            end
            if (!w_done) begin
                check("rnd_wvalid", wvalid, 1);
                check("rnd_wdata", wdata, data);
                if (cw == dw) begin wready = 1; w_hs = 1; sw = wdata; end
                cw++;
            end
            if (wr && !(a_done && w_done)) check("rnd_bready_early", bready, 0);
            if (d_hs) begin
                bvalid = 0; rvalid = 0; d_done = 1; d_hs = 0;
                if (wr) slave_mem[sa[5:2]] = sw;
            end else if (a_done && w_done && !d_done) begin
                if (cb >= db) begin
                    if (wr) begin bvalid = 1; bresp = sresp; end
                    else begin rvalid = 1; rdata = slave_mem[sa[5:2]]; rresp = sresp; end
                end
                cb++;
            end
            d_hs = (bvalid && bready) || (rvalid && rready);
            rsp_ready = 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
                check("rnd_rsp_resp", rsp_resp, sresp);
                check("rnd_rsp_rdata", rsp_rdata, exp_rdata);
                check("rnd_rsp_timeout", rsp_timeout, 0);
                done = 1;
            end
            tick();
            if (a_hs) a_done = 1;
            if (w_hs) w_done = 1;
        end
        check("rnd_done", done, 1);
        rsp_ready = 0;
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slave_mem[i] = '0; end
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}, 0);
        check("rst_payload", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        check("rst_addr_data", {awaddr, wdata}, 0);
        rst_n = 1;
        tick();

        // Write with an always-ready slave
        rsp_ready = 1; awready = 1; wready = 1;
        issue(1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("w1_c1_valids", {awvalid, wvalid, cmd_ready, busy}, 4'b1101);
        check("w1_c1_awaddr", awaddr, 32'h10);
        check("w1_c1_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        awready = 0; wready = 0;
        check("w1_c2", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        check("w1_c3_rsp", {rsp_valid, rsp_resp, rsp_timeout, bready}, 5'b10000);
        check("w1_c3_rdata", rsp_rdata, 0);
        tick();
        check("w1_c4", {cmd_ready, rsp_valid, busy}, 3'b100);

        // AW at cycle 1, W at cycle 4, B at cycle 6
        awready = 1;
        issue(1, 32'h0000_0014, 32'h0BAD_F00D);
        check("w2_c1", {awvalid, wvalid}, 2'b11);
        tick();
        awready = 0;
        for (int c = 2; c <= 4; c++) begin
            check("w2_wvalid_held", {awvalid, wvalid, bready}, 3'b010);
            if (c == 4) wready = 1;
            tick();
        end
        wready = 0;
        check("w2_c5", {wvalid, bready, rsp_valid}, 3'b010);
        tick();
        bvalid = 1; bresp = 2'b11;
        tick();
        bvalid = 0;
        check("w2_c7_rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1110);
        tick();

        // Read with a 3-cycle arready stall and a 5-cycle rsp_ready stall
        rsp_ready = 0;
        issue(0, 32'h0000_0020, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            check("r1_ar_stall", {arvalid, rready}, 2'b10);
            check("r1_araddr", araddr, 32'h20);
            tick();
        end
        arready = 1;
        check("r1_c4_arvalid", arvalid, 1);
        tick();
        arready = 0;
        check("r1_c5", {arvalid, rready}, 2'b01);
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick();
        rvalid = 0; rdata = 32'hFFFF_FFFF;
        for (int c = 6; c <= 10; c++) begin
            check("r1_rsp_hold", {rsp_valid, rsp_resp, rsp_timeout, cmd_ready, rready}, 6'b100000);
            check("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
            if (c == 10) rsp_ready = 1;
            tick();
        end
        check("r1_c11", {cmd_ready, rsp_valid}, 2'b10);

        // Watchdog expiry on a write whose B arrives late at cycle 40
        awready = 1; wready = 1;
        issue(1, 32'h0000_0030, 32'h5555_AAAA);
        tick();
        awready = 0; wready = 0;
        for (int c = 2; c < 17; c++) begin
            check("to_no_rsp", rsp_valid, 0);
            tick();
        end
        check("to_c17_rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1101);
        check("to_c17_rdata", rsp_rdata, 0);
        check("to_c17_bready", bready, 1);
        tick();
        check("to_c18_drain", {rsp_valid, cmd_ready, busy, bready}, 4'b0011);
        for (int c = 18; c < 40; c++) begin
            check("to_drain_cmd_ready", cmd_ready, 0);
            tick();
        end
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        check("to_c41", {cmd_ready, busy, bready}, 3'b100);
        run_txn(0, 32'h0000_0110, 32'h0, 2'b00);

        // R handshake in the very cycle the watchdog expires
        rsp_ready = 1; arready = 1;
        issue(0, 32'h0000_0040, 32'h0);
        tick();
        arready = 0;
        check("edge_rready", rready, 1);
        for (int c = 2; c < 16; c++) begin
            check("edge_no_rsp", rsp_valid, 0);
            tick();
        end
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
        check("edge_c16_no_rsp", rsp_valid, 0);
        tick();
        rvalid = 0;
        check("edge_c17_rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1010);
        check("edge_c17_rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();
        check("edge_c18_idle", {cmd_ready, busy}, 2'b10);

        // Asynchronous reset while waiting for B
        awready = 1; wready = 1;
        issue(1, 32'h0000_0050, 32'h1111_2222);
        tick();
        awready = 0; wready = 0;
        check("rst_mid_bready", bready, 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_async", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}, 0);
        tick();
        rst_n = 1;
        tick();
        check("rst_mid_release", {cmd_ready, busy}, 2'b10);
        rsp_ready = 0;

        // Randomized transactions against a memory reference model
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            a = 32'h0000_0100 | ({28'h0, 4'($urandom_range(0, 15))} << 2);
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
